// File: rtl/md5_mac_check.sv
// ---------------------------------------------------------------------------
// md5_mac_check
//   Front end and result checker for the fixed-latency MD5 HMAC pipeline.
//   Accepts line-verify commands, forms the 1024-bit pipeline input
//   (ipad ^ {key, addrcnt, zeros} over the line data), tracks in-flight tags
//   in order, compares each returned digest with the expected MAC and buffers
//   the verdicts for the consumer.
//
//   Optional feature: define MD5_MAC_WATCHDOG_EN to enable the in-flight age
//   watchdog driving err_timeout (tied 0 otherwise).
//
// Ports
//   clk, rst (async, active low)
//   key                       HMAC key, sampled at command accept
//   cmd_valid/cmd_ready       command handshake
//   cmd_addrcnt/data/mac/id   command payload
//   md5_req, md5_in           one-cycle request and input to the pipeline
//   md5_ready, md5_out        pipeline result strobe and digest
//   res_valid/res_ready       verdict handshake
//   res_id/res_pass/res_mac   verdict payload
//   err_spurious              sticky: result with nothing outstanding
//   err_timeout               sticky watchdog flag
// ---------------------------------------------------------------------------
module md5_mac_check #(
    parameter int KEY_W     = 64,
    parameter int ADDRCNT_W = 64,
    parameter int ID_W      = 4,
    parameter int DEPTH     = 8,
    parameter int DRAIN     = 134,
    parameter int TIMEOUT   = 160
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_W-1:0]     key,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDRCNT_W-1:0] cmd_addrcnt,
    input  logic [511:0]         cmd_data,
    input  logic [127:0]         cmd_mac,
    input  logic [ID_W-1:0]      cmd_id,
    output logic                 md5_req,
    output logic [1023:0]        md5_in,
    input  logic                 md5_ready,
    input  logic [127:0]         md5_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic                 res_pass,
    output logic [127:0]         res_mac,
    output logic                 err_spurious,
    output logic                 err_timeout
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int DCW   = $clog2(DRAIN + 2);
    localparam int PAD_W = 512 - KEY_W - ADDRCNT_W;
    localparam logic [511:0] IPAD = {64{8'h36}};

    typedef enum logic {S_DRAIN, S_RUN} state_t;

    state_t          state, state_nx;
    logic [DCW-1:0]  drain_cnt;
    logic [CW-1:0]   credits;

    logic accept, res_pop, rsp, tag_pop, spurious;

    // tag / expected-MAC FIFO
    logic [ID_W-1:0] tag_id  [DEPTH];
    logic [127:0]    tag_mac [DEPTH];
    logic [AW:0]     tag_wp, tag_rp;
    logic            tag_empty;

    // result FIFO behind the registered output stage
    logic [ID_W-1:0] rf_id   [DEPTH];
    logic            rf_pass [DEPTH];
    logic [127:0]    rf_mac  [DEPTH];
    logic [AW:0]     rf_wp, rf_rp;
    logic            rf_empty, load_out, rf_pop, rf_write, cmp_pass;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_DRAIN;
            drain_cnt <= DCW'(DRAIN);
        end else begin
            state <= state_nx;
            if (state == S_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Leaving on the count-of-1 cycle makes the drain window exactly DRAIN cycles.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        case (state)
            S_DRAIN: if (drain_cnt <= DCW'(1)) state_nx = S_RUN;
            S_RUN:   cmd_ready = (credits < CW'(DEPTH));
            default: state_nx = S_DRAIN;
        endcase
    end

    assign accept    = cmd_valid & cmd_ready;
    assign res_pop   = res_valid & res_ready;
    assign tag_empty = (tag_wp == tag_rp);
    assign rsp       = md5_ready & (state == S_RUN);
    assign tag_pop   = rsp & ~tag_empty;
    assign spurious  = rsp & tag_empty;

    // ---------------- credits ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits <= '0;
        end else begin
            case ({accept, res_pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    // ---------------- issue ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md5_req <= 1'b0;
            md5_in  <= '0;
        end else begin
            md5_req <= accept;
            if (accept)
                md5_in <= {IPAD ^ {key, cmd_addrcnt, {PAD_W{1'b0}}}, cmd_data};
        end
    end

    // ---------------- tag FIFO ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_id[tag_wp[AW-1:0]]  <= cmd_id;
            tag_mac[tag_wp[AW-1:0]] <= cmd_mac;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wp <= '0;
            tag_rp <= '0;
        end else begin
            if (accept)  tag_wp <= tag_wp + 1'b1;
            if (tag_pop) tag_rp <= tag_rp + 1'b1;
        end
    end

    assign cmp_pass = (md5_out == tag_mac[tag_rp[AW-1:0]]);

    // ---------------- result FIFO + output register ----------------
    // A fresh result bypasses the memory when the output stage is free and
    // nothing older is queued, giving one cycle from md5_ready to res_valid.
    assign rf_empty = (rf_wp == rf_rp);
    assign load_out = ~res_valid | res_pop;
    assign rf_pop   = load_out & ~rf_empty;
    assign rf_write = tag_pop & ~(load_out & rf_empty);

    always_ff @(posedge clk) begin
        if (rf_write) begin
            rf_id[rf_wp[AW-1:0]]   <= tag_id[tag_rp[AW-1:0]];
            rf_pass[rf_wp[AW-1:0]] <= cmp_pass;
            rf_mac[rf_wp[AW-1:0]]  <= md5_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wp     <= '0;
            rf_rp     <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_pass  <= 1'b0;
            res_mac   <= '0;
        end else begin
            if (rf_write) rf_wp <= rf_wp + 1'b1;
            if (rf_pop)   rf_rp <= rf_rp + 1'b1;
            if (load_out) begin
                if (!rf_empty) begin
                    res_valid <= 1'b1;
                    res_id    <= rf_id[rf_rp[AW-1:0]];
                    res_pass  <= rf_pass[rf_rp[AW-1:0]];
                    res_mac   <= rf_mac[rf_rp[AW-1:0]];
                end else if (tag_pop) begin
                    res_valid <= 1'b1;
                    res_id    <= tag_id[tag_rp[AW-1:0]];
                    res_pass  <= cmp_pass;
                    res_mac   <= md5_out;
                end else begin
                    res_valid <= 1'b0;
                end
            end
        end
    end

    // ---------------- errors ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_spurious <= 1'b0;
        else if (spurious)
            err_spurious <= 1'b1;
    end

`ifdef MD5_MAC_WATCHDOG_EN
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    logic [AGE_W-1:0] age;

    // Age saturates at TIMEOUT so a long stall cannot wrap the counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age         <= '0;
            err_timeout <= 1'b0;
        end else if (tag_pop || (accept && tag_empty)) begin
            age <= '0;
        end else if (!tag_empty) begin
            if (age == AGE_W'(TIMEOUT - 1))
                err_timeout <= 1'b1;
            if (age != AGE_W'(TIMEOUT))
                age <= age + 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule
